// File: rtl/bsg_fpu_pkg.sv
// Shared FPU package: the state encoding for the sequential mantissa aligner.
package bsg_fpu_pkg;

  // eIdle waits for a request, eShift walks the shift, eDone holds the result.
  typedef enum logic [1:0] {
    eIdle  = 2'd0,
    eShift = 2'd1,
    eDone  = 2'd2
  } align_state_e;

endpackage : bsg_fpu_pkg

// File: rtl/bsg_fpu_sticky.sv
// Sticky-bit generator: ORs the bits of i_i that a right shift by shamt_i would
// discard.
//   i_i      : operand, width_p bits
//   shamt_i  : shift amount, lg(width_p)+1 bits (values >= width_p cover all bits)
//   sticky_o : OR of i_i[shamt_i-1:0], 0 when shamt_i is 0 (combinational)
module bsg_fpu_sticky #(
  parameter  int unsigned width_p    = 16,
  localparam int unsigned shamt_w_lp = $clog2(width_p) + 1
) (
  input  logic [width_p-1:0]    i_i,
  input  logic [shamt_w_lp-1:0] shamt_i,
  output logic                  sticky_o
);

  // A bit is discarded when its index lies below the shift amount.
  always_comb begin
    sticky_o = 1'b0;
    for (int unsigned j = 0; j < width_p; j++) begin
      if (shamt_w_lp'(j) < shamt_i) begin
        sticky_o = sticky_o | i_i[j];
      end
    end
  end

endmodule : bsg_fpu_sticky

// File: rtl/bsg_fpu_align_seq.sv
// Sequential mantissa aligner: right-shifts data_i by shamt_i (clamped to
// width_p) at most step_p bits per cycle, accumulating a sticky bit from every
// bit shifted out. Valid/ready request side, valid/yumi result side.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   v_i, ready_o     : request handshake (ready_o high only when idle)
//   data_i, shamt_i  : mantissa and right-shift amount, sampled at accept
//   v_o, yumi_i      : result handshake (yumi_i legal only while v_o is high)
//   data_o, sticky_o : aligned mantissa and OR of all shifted-out bits
module bsg_fpu_align_seq
  import bsg_fpu_pkg::*;
#(
  parameter  int unsigned width_p    = 16,
  parameter  int unsigned step_p     = 4,
  localparam int unsigned shamt_w_lp = $clog2(width_p) + 1
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,

  input  logic                  v_i,
  output logic                  ready_o,
  input  logic [width_p-1:0]    data_i,
  input  logic [shamt_w_lp-1:0] shamt_i,

  output logic                  v_o,
  output logic [width_p-1:0]    data_o,
  output logic                  sticky_o,
  input  logic                  yumi_i
);

  localparam logic [shamt_w_lp-1:0] WidthShamt = shamt_w_lp'(width_p);
  localparam logic [shamt_w_lp-1:0] StepShamt  = shamt_w_lp'(step_p);

  align_state_e          state_q, state_d;
  logic [width_p-1:0]    data_q, data_d;
  logic                  sticky_q, sticky_d;
  logic [shamt_w_lp-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  v_q, v_d;

  logic [shamt_w_lp-1:0] shamt_clamp;
  logic [shamt_w_lp-1:0] step_k;
  logic                  step_sticky;

  // Shifts beyond the mantissa width all produce the same result.
  assign shamt_clamp = (shamt_i > WidthShamt) ? WidthShamt : shamt_i;

  // This cycle's shift: the full step unless less than a step remains.
  assign step_k = (cnt_q < StepShamt) ? cnt_q : StepShamt;

  // Bits about to fall off the bottom of the data register this cycle.
  bsg_fpu_sticky #(
    .width_p (width_p)
  ) sticky_u (
    .i_i      (data_q),
    .shamt_i  (step_k),
    .sticky_o (step_sticky)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      eIdle: begin
        if (v_i) begin
          data_d   = data_i;
          sticky_d = 1'b0;
          cnt_d    = shamt_clamp;
          state_d  = (shamt_clamp == '0) ? eDone : eShift;
        end
      end
      eShift: begin
        data_d   = data_q >> step_k;
        sticky_d = sticky_q | step_sticky;
        cnt_d    = cnt_q - step_k;
        if (cnt_q == step_k) begin
          state_d = eDone;
        end
      end
      eDone: begin
        if (yumi_i) begin
          state_d = eIdle;
        end
      end
      default: begin
        state_d = eIdle;
      end
    endcase

    ready_d = (state_d == eIdle);
    v_d     = (state_d == eDone);
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= eIdle;
      data_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      v_q      <= v_d;
    end
  end

  assign ready_o  = ready_q;
  assign v_o      = v_q;
  assign data_o   = data_q;
  assign sticky_o = sticky_q;

  // The consumer may only take a result that is being offered.
  yumi_only_when_valid_a : assert property (
    @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o
  ) else $error("bsg_fpu_align_seq: yumi_i asserted while v_o is low");

endmodule : bsg_fpu_align_seq
